// File: rtl/inv_cipher_core_pkg.sv
// Shared types, inverse S-box and GF(2^8) helpers for the iterative AES inverse cipher.
package inv_cipher_core_pkg;

  localparam int NB = 4;

  typedef logic [7:0] t_byte;
  // [col][row] byte layout, identical to the forward cipher state
  typedef t_byte [NB-1:0][3:0] t_state;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} t_fsm;

  localparam t_byte INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic t_byte xtime(input t_byte b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic t_byte gmul9(input t_byte b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic t_byte gmul11(input t_byte b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic t_byte gmul13(input t_byte b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic t_byte gmul14(input t_byte b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Row r rotates right by r columns; 2-bit truncation gives the mod-4 wrap
  function automatic t_state inv_shift_rows(input t_state s);
    t_state o;
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++)
        o[2'(c)][2'(r)] = s[2'(c - r)][2'(r)];
    return o;
  endfunction

  function automatic t_state inv_sub_bytes(input t_state s);
    t_state o;
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++)
        o[2'(c)][2'(r)] = INV_SBOX[s[2'(c)][2'(r)]];
    return o;
  endfunction

  function automatic t_state inv_mix_columns(input t_state s);
    t_state o;
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++)
        o[2'(c)][2'(r)] = gmul14(s[2'(c)][2'(r)])     ^ gmul11(s[2'(c)][2'(r + 1)]) ^
                          gmul13(s[2'(c)][2'(r + 2)]) ^ gmul9(s[2'(c)][2'(r + 3)]);
    return o;
  endfunction

endpackage

// File: rtl/inv_cipher_core_if.sv
// Block handshakes, round-key store port and status of the inverse cipher core.
interface inv_cipher_core_if
  import inv_cipher_core_pkg::*;
#(
  parameter int RKI_W = 4
);
  logic             in_valid;
  logic             in_ready;
  t_state           in_data;
  logic [RKI_W-1:0] rk_idx;
  t_state           rk;
  logic             out_valid;
  logic             out_ready;
  t_state           out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, rk, out_ready,
    input  in_ready, rk_idx, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, rk, out_ready,
    output in_ready, rk_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/inv_cipher_core_inv_round.sv
// One combinational inverse round; the last round skips InvMixColumns.
module inv_round
  import inv_cipher_core_pkg::*;
(
  input  t_state st_i,
  input  t_state rk_i,
  input  logic   last_i,
  output t_state st_o
);
  t_state keyed;

  always_comb begin
    keyed = inv_sub_bytes(inv_shift_rows(st_i)) ^ rk_i;
    st_o  = last_i ? keyed : inv_mix_columns(keyed);
  end
endmodule

// File: rtl/inv_cipher_core.sv
// Iterative AES inverse cipher: initial AddRoundKey on accept, then one round per clock.
module inv_cipher_core
  import inv_cipher_core_pkg::*;
#(
  parameter int NR    = 10,
  parameter int RKI_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  inv_cipher_core_if.slave core_if
);
  t_fsm             state_q, state_d;
  logic [RKI_W-1:0] rnd_q, rnd_d;
  t_state           st_q, st_d;
  t_state           roundSt;
  logic             lastRound;
  logic             inReady;
  logic             outValid;
  logic             busyFlag;
  logic [RKI_W-1:0] rkIdx;

  inv_round u_round (
    .st_i   (st_q),
    .rk_i   (core_if.rk),
    .last_i (lastRound),
    .st_o   (roundSt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= RKI_W'(NR);
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
    end
  end

  // rk_idx depends only on registered state, so the key store sees a stable address all cycle
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    st_d      = st_q;
    inReady   = 1'b0;
    outValid  = 1'b0;
    busyFlag  = 1'b1;
    lastRound = 1'b0;
    rkIdx     = RKI_W'(NR);
    unique case (state_q)
      S_IDLE: begin
        inReady  = 1'b1;
        busyFlag = 1'b0;
        if (core_if.in_valid) begin
          st_d    = core_if.in_data ^ core_if.rk;
          rnd_d   = RKI_W'(NR - 1);
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        rkIdx = rnd_q;
        st_d  = roundSt;
        rnd_d = rnd_q - RKI_W'(1);
        if (rnd_q == RKI_W'(1)) state_d = S_FINAL;
      end
      S_FINAL: begin
        rkIdx     = '0;
        lastRound = 1'b1;
        st_d      = roundSt;
        state_d   = S_DONE;
      end
      S_DONE: begin
        outValid = 1'b1;
        if (core_if.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign core_if.in_ready  = inReady;
  assign core_if.out_valid = outValid;
  assign core_if.busy      = busyFlag;
  assign core_if.rk_idx    = rkIdx;
  assign core_if.out_data  = (state_q == S_DONE) ? st_q : '0;

endmodule
